i2c_master_ctrl: RTL
====================

// Module: i2c_master_ctrl
// PURPOSE
//  Single-master I2C initiator issuing 8-bit register write/read transactions (7-bit device addr).
//  Drives the t_i2c bus from the master end, opposite the responder/sniffer on the same net.
//  Sits between MCOI control logic (e.g. PCB EEPROM/sensor access) and the board I2C pins.
// PARAMETERS
//  QDIV        250   clk cycles per SCL quarter-period (100MHz/(4*250) = 100kHz SCL)
//  QDIV_W      16    width of quarter-period counter; QDIV must be < 2**QDIV_W
// PORTS
//  ClkRs_ix     in    ckrs_t  clock .clk; reset .reset (asynchronous, active-high)
//  req_i        in    1       start transaction; sampled only while busy_o=0
//  rnw_i        in    1       1=read, 0=write; captured with req_i
//  dev_addr_b7  in    7       device address; captured with req_i
//  reg_addr_b8  in    8       register address; captured with req_i
//  wdata_b8     in    8       write data; captured with req_i
//  busy_o       out   1       transaction in progress
//  done_o       out   1       1-cycle pulse at transaction end (after STOP)
//  nack_o       out   1       valid with done_o: any slave NACK seen
//  rdata_b8     out   8       read byte; valid from done_o until next done_o
//  i2c_x        inout t_i2c.endpoint  SCL/SDA, open-drain: drive '0' or 'z' only
// BEHAVIOUR
//  Reset: busy_o=0, done_o=0, nack_o=0, rdata_b8=0, SCL/SDA released ('z), state IDLE, timer 0.
//  Reset mid-transaction releases both lines on the reset edge; no STOP generated.
//  Timing: quarter tick every QDIV clks; each bit = 4 quarters (SCL low,low,high,high);
//   SDA changes only in quarter 0 (SCL low); sampled at end of quarter 2.
//  Handshake: req_i & ~busy_o -> capture inputs, busy_o=1 next cycle. req_i while busy ignored.
//  FSM: IDLE -> START(SDA low while SCL high, 2 quarters) -> ADDR(dev,0) -> ACK1 -> REG -> ACK2
//   write: -> WDATA -> ACK3 -> STOP
//   read : -> RSTART(repeated start) -> ADDR(dev,1) -> ACK4 -> RDATA(MSB first) -> MNACK -> STOP
//   STOP: SDA low->release while SCL high; then DONE (1 clk: done_o=1, busy_o=0) -> IDLE.
//  Any ACK slot sampling SDA=1: nack_o latched 1, go straight to STOP (no further bytes).
//  Bit counter 3 bits, counts 7 downto 0; wrap at 0 moves to ACK state.
//  MNACK: master leaves SDA released (NACK) after the single read byte.
//  Latency write: START + 27 bits + STOP; read: START + 18 + RSTART + 18 + STOP bits.
//  nack_o cleared on capture of new request; rdata_b8 updated only on successful read.
//  Arbitration/multi-master not supported; SDA readback mismatch ignored.
// CONFIGURATION
//  I2C_CLK_STRETCH_EN defined: on entering quarter 2 the timer holds while sampled SCL=0
//   (slave stretching); continues once SCL reads 1; no timeout.
//  Not defined: SCL level not sampled; timing purely from quarter ticks.
// STRUCTURE
//  types pkg: i2c_master_state_t enum (IDLE,START,ADDR,ACK,REG,WDATA,RSTART,RDATA,MNACK,STOP,DONE).
//  constants pkg: I2C_RD=1'b1, I2C_WR=1'b0, default QDIV for 100kHz.
//  Sub-module: i2c_quarter_timer (QDIV counter -> qtick pulse + 2-bit quarter index, hold input).
// TESTING (bench: behavioural I2C responder model on t_i2c, pull-ups on both lines)
//  1 write dev=0x50 reg=0x12 data=0xA5, model ACKs -> bus bytes A0,12,A5, STOP; done_o, nack_o=0.
//  2 read dev=0x50 reg=0x12, model returns 0x3C -> bytes A0,12,Sr,A1; rdata_b8=0x3C, master NACK.
//  3 no device at 0x33 -> NACK on addr byte; STOP follows ACK1; done_o with nack_o=1, no REG byte.
//  4 reset asserted during REG byte -> SCL/SDA 'z same edge, busy_o=0; next req completes cleanly.
//  5 req_i pulsed while busy_o=1 with other dev addr -> ignored; only first transaction on bus.
//  6 (I2C_CLK_STRETCH_EN) model holds SCL low 1000 clks in ACK2 -> bit period grows by ~1000 clks.

Source files
------------

// File: rtl/i2c_master_ctrl_pkg.sv
// Shared types and constants for the I2C master controller.
// Also holds the clock/reset bundle used on the controller port.
package i2c_master_ctrl_pkg;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK, REG, WDATA,
        RSTART, RDATA, MNACK, STOP, DONE
    } i2c_master_state_t;

    // Which byte the shared shift register is carrying.
    typedef enum logic [1:0] {
        PH_DEVW, PH_REG, PH_WDATA, PH_DEVR
    } i2c_phase_t;

    localparam logic I2C_RD        = 1'b1;
    localparam logic I2C_WR        = 1'b0;
    localparam int   I2C_QDIV_100K = 250;

endpackage

// File: rtl/t_i2c.sv
// Open-drain I2C net: each side only pulls a line low (oe=1) or releases it.
// Pull-ups are implied: a line reads 1 unless somebody pulls it low.
interface t_i2c;
    logic scl_m_oe;
    logic sda_m_oe;
    logic scl_s_oe;
    logic sda_s_oe;
    logic scl;
    logic sda;

    assign scl = ~(scl_m_oe | scl_s_oe);
    assign sda = ~(sda_m_oe | sda_s_oe);

    modport endpoint (output scl_m_oe, output sda_m_oe, input scl, input sda);
    modport responder (output scl_s_oe, output sda_s_oe, input scl, input sda);
endinterface

// File: rtl/i2c_master_ctrl_quarter_timer.sv
// SCL quarter-period timer: qtick every QDIV clks plus a 2-bit quarter index.
// i_load restarts at quarter 2 so START occupies the high half of a bit.
module i2c_quarter_timer #(
    parameter int QDIV   = 250,
    parameter int QDIV_W = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic       i_load,
    input  logic       i_hold,
    output logic       o_qtick,
    output logic [1:0] o_quarter
);

    localparam logic [QDIV_W-1:0] LP_LAST = QDIV_W'(QDIV - 1);

    logic [QDIV_W-1:0] r_cnt;
    logic [1:0]        r_q;

    assign o_qtick   = i_run & ~i_hold & (r_cnt == LP_LAST);
    assign o_quarter = r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_q   <= 2'd0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_q   <= 2'd2;
        end else if (!i_run) begin
            r_cnt <= '0;
            r_q   <= 2'd0;
        end else if (!i_hold) begin
            if (r_cnt == LP_LAST) begin
                r_cnt <= '0;
                r_q   <= r_q + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C register write/read initiator (7-bit device address).
// Optional I2C_CLK_STRETCH_EN: quarter 2 waits while SCL is held low by a slave.
module i2c_master_ctrl
    import i2c_master_ctrl_pkg::*;
#(
    parameter int QDIV   = I2C_QDIV_100K,
    parameter int QDIV_W = 16
) (
    input  ckrs_t       ClkRs_ix,
    input  logic        req_i,
    input  logic        rnw_i,
    input  logic [6:0]  dev_addr_b7,
    input  logic [7:0]  reg_addr_b8,
    input  logic [7:0]  wdata_b8,
    output logic        busy_o,
    output logic        done_o,
    output logic        nack_o,
    output logic [7:0]  rdata_b8,
    t_i2c.endpoint      i2c_x
);

    logic w_clk;
    logic w_rst;
    assign w_clk = ClkRs_ix.clk;
    assign w_rst = ClkRs_ix.reset;

    i2c_master_state_t r_state;
    i2c_master_state_t w_state_nx;
    i2c_phase_t        r_phase;

    logic [2:0] r_bit;
    logic [7:0] r_sh;
    logic       r_rnw;
    logic [6:0] r_dev;
    logic [7:0] r_reg;
    logic [7:0] r_wdata;
    logic       r_nack;
    logic [7:0] r_rdata;
    logic       r_scl_oe;
    logic       r_sda_pre;
    logic       r_sda_oe;
    logic [1:0] r_sda_s;

    logic       w_cap;
    logic       w_qtick;
    logic [1:0] w_q;
    logic       w_qend;
    logic       w_samp;
    logic       w_hold;
    logic       w_sda_in;
    logic       w_scl_oe;
    logic       w_sda_oe;

    assign busy_o   = (r_state != IDLE) && (r_state != DONE);
    assign done_o   = (r_state == DONE);
    assign nack_o   = r_nack;
    assign rdata_b8 = r_rdata;
    assign w_cap    = req_i & ~busy_o;
    assign w_qend   = w_qtick & (w_q == 2'd3);
    assign w_samp   = w_qtick & (w_q == 2'd2);
    assign w_sda_in = r_sda_s[1];

    assign i2c_x.scl_m_oe = r_scl_oe;
    assign i2c_x.sda_m_oe = r_sda_oe;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] r_scl_s;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) r_scl_s <= 2'b11;
        else       r_scl_s <= {r_scl_s[0], i2c_x.scl};
    end

    assign w_hold = (w_q == 2'd2) & ~r_scl_s[1];
`else
    assign w_hold = 1'b0;
`endif

    i2c_quarter_timer #(
        .QDIV   (QDIV),
        .QDIV_W (QDIV_W)
    ) u_timer (
        .i_clk     (w_clk),
        .i_rst     (w_rst),
        .i_run     (busy_o),
        .i_load    (w_cap),
        .i_hold    (w_hold),
        .o_qtick   (w_qtick),
        .o_quarter (w_q)
    );

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) r_state <= IDLE;
        else       r_state <= w_state_nx;
    end

    // Quarters 0,1 pull SCL low; START/RSTART/STOP shape SDA inside the high half.
    always_comb begin
        w_state_nx = r_state;
        w_scl_oe   = 1'b0;
        w_sda_oe   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cap) w_state_nx = START;
            end
            START: begin
                w_sda_oe = (w_q == 2'd3);
                if (w_qend) w_state_nx = ADDR;
            end
            ADDR, REG, WDATA: begin
                w_scl_oe = ~w_q[1];
                w_sda_oe = ~r_sh[7];
                if (w_qend && r_bit == 3'd0) w_state_nx = ACK;
            end
            ACK: begin
                w_scl_oe = ~w_q[1];
                if (w_qend) begin
                    if (r_nack) begin
                        w_state_nx = STOP;
                    end else begin
                        unique case (r_phase)
                            PH_DEVW:  w_state_nx = REG;
                            PH_REG:   w_state_nx = (r_rnw == I2C_RD) ? RSTART : WDATA;
                            PH_WDATA: w_state_nx = STOP;
                            PH_DEVR:  w_state_nx = RDATA;
                        endcase
                    end
                end
            end
            RSTART: begin
                w_scl_oe = ~w_q[1];
                w_sda_oe = (w_q == 2'd3);
                if (w_qend) w_state_nx = ADDR;
            end
            RDATA: begin
                w_scl_oe = ~w_q[1];
                if (w_qend && r_bit == 3'd0) w_state_nx = MNACK;
            end
            MNACK: begin
                w_scl_oe = ~w_q[1];
                if (w_qend) w_state_nx = STOP;
            end
            STOP: begin
                w_scl_oe = ~w_q[1];
                w_sda_oe = (w_q != 2'd3);
                if (w_qend) w_state_nx = DONE;
            end
            DONE: begin
                w_state_nx = w_cap ? START : IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // SDA lags SCL by one clk so data never moves on an SCL edge.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_phase   <= PH_DEVW;
            r_bit     <= 3'd7;
            r_sh      <= 8'h00;
            r_rnw     <= 1'b0;
            r_dev     <= 7'h00;
            r_reg     <= 8'h00;
            r_wdata   <= 8'h00;
            r_nack    <= 1'b0;
            r_rdata   <= 8'h00;
            r_scl_oe  <= 1'b0;
            r_sda_pre <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_sda_s   <= 2'b11;
        end else begin
            r_scl_oe  <= w_scl_oe;
            r_sda_pre <= w_sda_oe;
            r_sda_oe  <= r_sda_pre;
            r_sda_s   <= {r_sda_s[0], i2c_x.sda};
            if (w_cap) begin
                r_rnw   <= rnw_i;
                r_dev   <= dev_addr_b7;
                r_reg   <= reg_addr_b8;
                r_wdata <= wdata_b8;
                r_nack  <= 1'b0;
            end
            if (r_state == START && w_qend) begin
                r_phase <= PH_DEVW;
                r_sh    <= {r_dev, I2C_WR};
                r_bit   <= 3'd7;
            end
            if (r_state == RSTART && w_qend) begin
                r_phase <= PH_DEVR;
                r_sh    <= {r_dev, I2C_RD};
                r_bit   <= 3'd7;
            end
            if ((r_state inside {ADDR, REG, WDATA}) && w_qend) begin
                r_sh  <= {r_sh[6:0], 1'b0};
                r_bit <= r_bit - 3'd1;
            end
            if (r_state == ACK && w_samp && w_sda_in) r_nack <= 1'b1;
            if (r_state == ACK && w_qend) begin
                r_bit <= 3'd7;
                if (r_phase == PH_DEVW) begin
                    r_phase <= PH_REG;
                    r_sh    <= r_reg;
                end else if (r_phase == PH_REG && r_rnw == I2C_WR) begin
                    r_phase <= PH_WDATA;
                    r_sh    <= r_wdata;
                end
            end
            if (r_state == RDATA && w_samp) r_sh <= {r_sh[6:0], w_sda_in};
            if (r_state == RDATA && w_qend) begin
                r_bit <= r_bit - 3'd1;
                if (r_bit == 3'd0) r_rdata <= r_sh;
            end
        end
    end

endmodule
